// File: rtl/seq_sdiv16x8.sv
// Iterative signed divider: 2*DW-bit dividend / DW-bit divisor, truncating, with a valid/ready handshake on both sides.
// Optional APPROX_DIV_EN macro skips the low APPROX_BITS quotient bits and forces the remainder to zero.
module seq_sdiv16x8 #(
  parameter int DW          = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     quotient,
  output logic [DW-1:0]     remainder,
  output logic              ovf,
  output logic              dz
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

`ifdef APPROX_DIV_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif
  localparam int SKIP  = APPROX_ON ? APPROX_BITS : 0;
  localparam int ITERS = DW - SKIP;
  localparam int CW    = $clog2(DW + 1);

  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [2*DW-1:0] abs_wide(input logic [2*DW-1:0] v);
    return v[2*DW-1] ? (~v + {{(2*DW-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic s);
    return s ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DW-1:0] sat_val(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

  state_t          state_r, state_next_s;
  logic [2*DW-1:0] n_r;
  logic [DW-1:0]   d_r;
  logic            sn_r, sd_r;
  logic [DW-1:0]   dmag_r;
  logic [DW-1:0]   rem_r;
  logic [DW-1:0]   quo_r;
  logic [CW-1:0]   cnt_r;
  logic            in_ready_d_s, out_valid_d_s;
  logic            in_ready_r, out_valid_r;
  logic [DW-1:0]   quotient_r, remainder_r;
  logic            ovf_r, dz_r;

  logic [2*DW-1:0] nmag_s;
  logic [DW-1:0]   dmag_s;
  logic            dz_s, pre_ovf_s;
  logic [DW:0]     shift_s;
  logic            ge_s;
  logic [DW-1:0]   diff_s;
  logic [DW-1:0]   q_mag_s, q_fix_s, r_fix_s;
  logic            neg_q_s, fix_ovf_s;

  // Operand magnitudes and the divide-by-zero / early-overflow prechecks used in PREP.
  always_comb begin
    nmag_s    = abs_wide(n_r);
    dmag_s    = neg_if(d_r, d_r[DW-1]);
    dz_s      = (d_r == {DW{1'b0}});
    pre_ovf_s = (nmag_s[2*DW-1:DW] >= dmag_s);
  end

  // One restoring step: the shifted partial remainder needs DW+1 bits before the compare.
  always_comb begin
    shift_s = {rem_r, quo_r[DW-1]};
    ge_s    = (shift_s >= {1'b0, dmag_r});
    diff_s  = shift_s[DW-1:0] - dmag_r;
  end

  // Sign application and signed range check on the magnitude quotient.
  always_comb begin
    q_mag_s = quo_r << SKIP;
    neg_q_s = sn_r ^ sd_r;
    q_fix_s = neg_if(q_mag_s, neg_q_s);
    if (neg_q_s) begin
      fix_ovf_s = (q_mag_s > SAT_NEG);
    end else begin
      fix_ovf_s = q_mag_s[DW-1];
    end
`ifdef APPROX_DIV_EN
    r_fix_s = {DW{1'b0}};
`else
    r_fix_s = neg_if(rem_r, sn_r);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = PREP;
        end else begin
          state_next_s = IDLE;
        end
      end
      PREP: begin
        if (dz_s || pre_ovf_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ITER;
        end
      end
      ITER: begin
        if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
          state_next_s = FIX;
        end else begin
          state_next_s = ITER;
        end
      end
      FIX: state_next_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d_s  = (state_next_s == IDLE);
    out_valid_d_s = (state_next_s == DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_d_s;
      out_valid_r <= out_valid_d_s;
    end
  end

  // Datapath: operand capture, magnitude setup, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r         <= {(2*DW){1'b0}};
      d_r         <= {DW{1'b0}};
      sn_r        <= 1'b0;
      sd_r        <= 1'b0;
      dmag_r      <= {DW{1'b0}};
      rem_r       <= {DW{1'b0}};
      quo_r       <= {DW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {DW{1'b0}};
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            n_r <= dividend;
            d_r <= divisor;
          end
        end
        PREP: begin
          sn_r   <= n_r[2*DW-1];
          sd_r   <= d_r[DW-1];
          dmag_r <= dmag_s;
          rem_r  <= nmag_s[2*DW-1:DW];
          quo_r  <= nmag_s[DW-1:0];
          cnt_r  <= CW'(ITERS);
          if (dz_s) begin
            quotient_r  <= {DW{1'b1}};
            remainder_r <= n_r[DW-1:0];
            dz_r        <= 1'b1;
            ovf_r       <= 1'b0;
          end else if (pre_ovf_s) begin
            quotient_r  <= sat_val(n_r[2*DW-1] ^ d_r[DW-1]);
            remainder_r <= {DW{1'b0}};
            dz_r        <= 1'b0;
            ovf_r       <= 1'b1;
          end
        end
        ITER: begin
          rem_r <= ge_s ? diff_s : shift_s[DW-1:0];
          quo_r <= {quo_r[DW-2:0], ge_s};
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          dz_r <= 1'b0;
          if (fix_ovf_s) begin
            quotient_r  <= sat_val(neg_q_s);
            remainder_r <= {DW{1'b0}};
            ovf_r       <= 1'b1;
          end else begin
            quotient_r  <= q_fix_s;
            remainder_r <= r_fix_s;
            ovf_r       <= 1'b0;
          end
        end
        DONE: begin
          // Flags are only meaningful while the result is offered.
          if (out_ready) begin
            ovf_r <= 1'b0;
            dz_r  <= 1'b0;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;

endmodule

// File: tb/tb_seq_sdiv16x8.sv
// Directed bench for seq_sdiv16x8: a behavioural integer-division model feeds a scoreboard queue
// that is popped when the divider presents each result.
module tb_seq_sdiv16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dz;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  seq_sdiv16x8 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division on plain integers; latency counts the accept edge as edge 1.
  function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
    exp_t e;
    int ni, di, an, ad, qi, ri, qm;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (di == 0) begin
      e.q = 8'hFF; e.r = n[7:0]; e.ovf = 1'b0; e.dz = 1'b1; e.lat = 2;
    end else begin
      an = (ni < 0) ? -ni : ni;
      ad = (di < 0) ? -di : di;
`ifdef APPROX_DIV_EN
      qm = (an / ad) & ~3;
      qi = ((ni < 0) != (di < 0)) ? -qm : qm;
      ri = 0;
      e.lat = ((an / 256) >= ad) ? 2 : 9;
`else
      qm = an / ad;
      qi = ni / di;
      ri = ni % di;
      e.lat = ((an / 256) >= ad) ? 2 : 11;
`endif
      e.dz = 1'b0;
      if (qi > 127 || qi < -128) begin
        e.ovf = 1'b1;
        e.q   = ((ni < 0) == (di < 0)) ? 8'h7F : 8'h80;
        e.r   = 8'h00;
      end else begin
        e.ovf = 1'b0;
        e.q   = 8'(qi);
        e.r   = 8'(ri);
      end
    end
    return e;
  endfunction

  task automatic accept(input logic [15:0] n, input logic [7:0] d);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    sb.push_back(model(n, d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] n, input logic [7:0] d, input bit hold);
    exp_t e;
    int   lat;
    accept(n, d);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i + 1;
        break;
      end
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("quotient", {24'd0, quotient}, {24'd0, e.q});
    check("remainder", {24'd0, remainder}, {24'd0, e.r});
    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
    check("dz", {31'd0, dz}, {31'd0, e.dz});
    check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h00;
        @(posedge clk);
        #1;
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_quotient", {24'd0, quotient}, {24'd0, e.q});
        check("hold_remainder", {24'd0, remainder}, {24'd0, e.r});
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_return", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 16'h0000;
    divisor   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_quotient", {24'd0, quotient}, 32'd0);
    check("reset_remainder", {24'd0, remainder}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h0064, 8'h07, 1'b0);   // 100/7
    run_op(16'hFF9C, 8'h07, 1'b0);   // -100/7
    run_op(16'h0064, 8'hF9, 1'b0);   // 100/-7
    run_op(16'hFF9C, 8'hF9, 1'b0);   // -100/-7
    run_op(16'h03E8, 8'h03, 1'b0);   // early overflow
    run_op(16'hFF00, 8'h02, 1'b0);   // exactly -128
    run_op(16'h0100, 8'h02, 1'b0);   // +128 overflows in FIX
    run_op(16'h1234, 8'h00, 1'b0);   // divide by zero
    run_op(16'h8000, 8'h80, 1'b0);   // most negative operands
    run_op(16'h3FFF, 8'h80, 1'b0);
    run_op(16'hC001, 8'h80, 1'b0);
    run_op(16'h007F, 8'h01, 1'b0);
    run_op(16'hFF80, 8'h01, 1'b0);
    run_op(16'h0005, 8'h07, 1'b0);
    run_op(16'h0064, 8'h07, 1'b1);   // held result, ignored in_valid

    // Reset in the middle of ITER: the pending result is dropped.
    accept(16'h0064, 8'h07);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0064, 8'h07, 1'b0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
